// File: rtl/tc_clk_gate_ctrl.sv
// Control FSM for an integrated clock-gating cell: gates the downstream domain
// after a run of idle cycles and re-enables it on a wake request.
module tc_clk_gate_ctrl #(
  parameter int IdleCycles  = 16,
  parameter int WakeLatency = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        gate_en_i,
  input  logic        busy_i,
  input  logic        req_i,
  input  logic        test_en_i,
  output logic        clk_en_o,
  output logic        ready_o,
  output logic        gated_o,
  output logic [15:0] gate_events_o
);

  localparam int MaxCnt   = (IdleCycles > WakeLatency) ? IdleCycles : WakeLatency;
  localparam int CntWidth = $clog2(MaxCnt + 1);

  if (IdleCycles < 1) begin : g_idle_check
    $error("tc_clk_gate_ctrl: IdleCycles must be >= 1");
  end
  if (WakeLatency < 0) begin : g_wake_check
    $error("tc_clk_gate_ctrl: WakeLatency must be >= 0");
  end

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_GATED = 2'd1,
    S_WAKE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] idle_q, idle_d;
  logic [CntWidth-1:0] wake_q, wake_d;
  logic [15:0]         events_q, events_d;
  logic                clk_en_d, ready_d, gated_d;
  logic                qualify;
  logic                wake_cond;

  assign qualify   = gate_en_i & ~busy_i & ~req_i & ~test_en_i;
  assign wake_cond = req_i | busy_i | ~gate_en_i | test_en_i;

  // State, counters and outputs share one register process so every output
  // is a flop and all three status bits switch on the same edge.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // independent of statement order.
    if (rst_i) begin
      state_q  <= S_RUN;
      idle_q   <= '0;
      wake_q   <= '0;
      events_q <= '0;
      clk_en_o <= 1'b1;
      ready_o  <= 1'b1;
      gated_o  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      wake_q   <= wake_d;
      events_q <= events_d;
      clk_en_o <= clk_en_d;
      ready_o  <= ready_d;
      gated_o  <= gated_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every variable and no latch
    // is inferred.
    state_d  = state_q;
    idle_d   = idle_q;
    wake_d   = wake_q;
    events_d = events_q;

    if (test_en_i) begin
      // Test mode forces the domain on immediately, skipping any wake delay.
      state_d = S_RUN;
      idle_d  = '0;
      wake_d  = '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (!qualify) begin
            idle_d = '0;
          end else if (int'(idle_q) == IdleCycles - 1) begin
            state_d = S_GATED;
            idle_d  = '0;
            if (events_q != 16'hFFFF) events_d = events_q + 16'd1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        S_GATED: begin
          if (wake_cond) begin
            state_d = (WakeLatency == 0) ? S_RUN : S_WAKE;
            wake_d  = '0;
          end
        end
        S_WAKE: begin
          if (int'(wake_q) == WakeLatency - 1) begin
            state_d = S_RUN;
            wake_d  = '0;
          end else begin
            wake_d = wake_q + 1'b1;
          end
        end
        default: begin
          state_d = S_RUN;
          idle_d  = '0;
          wake_d  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered above.
  always_comb begin
    clk_en_d = (state_d != S_GATED);
    ready_d  = (state_d == S_RUN);
    gated_d  = (state_d == S_GATED);
  end

  assign gate_events_o = events_q;

endmodule

// File: tb/tb_tc_clk_gate_ctrl.sv
// Directed bench for tc_clk_gate_ctrl: a vector table on an IdleCycles=4 /
// WakeLatency=2 instance plus hand sequences for the single-cycle corners.
module tb_tc_clk_gate_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, gate_en, busy, req, test_en;
  logic a_clk_en, a_ready, a_gated;
  logic b_clk_en, b_ready, b_gated;
  logic [15:0] a_events, b_events;

  int n_tests = 0;
  int n_fail  = 0;

  tc_clk_gate_ctrl #(.IdleCycles(4), .WakeLatency(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .gate_en_i(gate_en), .busy_i(busy), .req_i(req),
    .test_en_i(test_en), .clk_en_o(a_clk_en), .ready_o(a_ready), .gated_o(a_gated),
    .gate_events_o(a_events)
  );

  tc_clk_gate_ctrl #(.IdleCycles(1), .WakeLatency(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .gate_en_i(gate_en), .busy_i(busy), .req_i(req),
    .test_en_i(test_en), .clk_en_o(b_clk_en), .ready_o(b_ready), .gated_o(b_gated),
    .gate_events_o(b_events)
  );

  typedef struct {
    logic        rst, gate_en, busy, req, test_en;
    logic        clk_en, ready, gated;
    logic [15:0] events;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, g, b, q, t, ce, rd, gt, input logic [15:0] ev);
    vec_t v;
    v.rst = r; v.gate_en = g; v.busy = b; v.req = q; v.test_en = t;
    v.clk_en = ce; v.ready = rd; v.gated = gt; v.events = ev;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, g, b, q, t);
    rst = r; gate_en = g; busy = b; req = q; test_en = t;
  endtask

  // Inputs are applied 1 time unit after an edge; outputs are sampled the same way.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_a(input string name, input logic ce, rd, gt, input logic [15:0] ev);
    check({name, " outs"}, {13'd0, a_clk_en, a_ready, a_gated}, {13'd0, ce, rd, gt});
    check({name, " events"}, a_events, ev);
  endtask

  task automatic check_b(input string name, input logic ce, rd, gt, input logic [15:0] ev);
    check({name, " outs"}, {13'd0, b_clk_en, b_ready, b_gated}, {13'd0, ce, rd, gt});
    check({name, " events"}, b_events, ev);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    //   rst g b q t   ce rd gt events
    add(1, 1, 0, 0, 0,  1, 1, 0, 16'd0);  // reset held two cycles
    add(1, 1, 0, 0, 0,  1, 1, 0, 16'd0);
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd0);  // idle 1
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd0);  // idle 2
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd0);  // idle 3
    add(0, 1, 0, 0, 0,  0, 0, 1, 16'd1);  // idle 4 -> gated
    add(0, 1, 0, 0, 0,  0, 0, 1, 16'd1);  // stays gated
    add(0, 1, 0, 1, 0,  1, 0, 0, 16'd1);  // req pulse -> wake
    add(0, 1, 0, 0, 0,  1, 0, 0, 16'd1);  // wake cycle 2
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd1);  // ready after WakeLatency
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd1);  // idle 1
    add(0, 1, 1, 0, 0,  1, 1, 0, 16'd1);  // busy restarts count
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd1);
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd1);
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd1);
    add(0, 1, 0, 0, 0,  0, 0, 1, 16'd2);  // 4 fresh idle cycles -> gated
    add(0, 1, 1, 0, 0,  1, 0, 0, 16'd2);  // busy wakes
    add(0, 1, 0, 0, 1,  1, 1, 0, 16'd2);  // test_en in WAKE -> ready next edge
    add(0, 1, 0, 0, 1,  1, 1, 0, 16'd2);
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd2);
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd2);
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd2);
    add(0, 1, 0, 1, 0,  1, 1, 0, 16'd2);  // req on final idle cycle -> no gating
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd2);
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd2);
    add(0, 1, 0, 0, 0,  1, 1, 0, 16'd2);
    add(0, 1, 0, 0, 0,  0, 0, 1, 16'd3);  // gated
    add(1, 1, 0, 0, 0,  1, 1, 0, 16'd0);  // reset during GATED
    add(0, 0, 0, 0, 0,  1, 1, 0, 16'd0);  // gating disabled keeps running

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].gate_en, vecs[i].busy, vecs[i].req, vecs[i].test_en);
      step();
      check_a($sformatf("vec%0d", i), vecs[i].clk_en, vecs[i].ready, vecs[i].gated,
              vecs[i].events);
    end

    // IdleCycles=1 / WakeLatency=0 corners.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_b("b_reset", 1'b1, 1'b1, 1'b0, 16'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_b("b_single_idle_gates", 1'b0, 1'b0, 1'b1, 16'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check_b("b_wake_zero_latency", 1'b1, 1'b1, 1'b0, 16'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_b("b_regate", 1'b0, 1'b0, 1'b1, 16'd2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check_b("b_test_en_in_gated", 1'b1, 1'b1, 1'b0, 16'd2);

    // Saturation: preload the event counter just below its ceiling.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    force dut_a.events_q = 16'hFFFE;
    #1;
    release dut_a.events_q;
    repeat (4) step();
    check_a("sat_first", 1'b0, 1'b0, 1'b1, 16'hFFFF);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    check_a("sat_rewake", 1'b1, 1'b1, 1'b0, 16'hFFFF);
    repeat (4) step();
    check_a("sat_hold", 1'b0, 1'b0, 1'b1, 16'hFFFF);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_a("sat_reset_clears", 1'b1, 1'b1, 1'b0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
